// File: rtl/block_dispatch_multislot.sv
// Round-robin thread-block dispatcher with multi-slot cores and completion tracking.
// Optional DISPATCH_STATS_EN adds busy-cycle and stall counters.
module block_dispatch_multislot #(
  parameter int NUM_CORES      = 4,
  parameter int SLOTS_PER_CORE = 2,
  parameter int ID_W           = 32,
  parameter int CNT_W          = $clog2(SLOTS_PER_CORE + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [31:0]                num_threads,
  input  logic [31:0]                block_dim,
  output logic                       busy,
  output logic                       kernel_done,
  output logic [1:0]                 err,
  output logic [NUM_CORES-1:0]       disp_valid,
  input  logic [NUM_CORES-1:0]       disp_ready,
  output logic [ID_W-1:0]            disp_block_id,
  input  logic [NUM_CORES-1:0]       core_done,
  output logic [NUM_CORES*CNT_W-1:0] core_inflight
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                stat_cycles,
  output logic [31:0]                stat_stall
`endif
);

  localparam int RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISP,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      nb_q, nb_d;
  logic [ID_W-1:0]      next_q, next_d;
  logic [ID_W-1:0]      ret_q, ret_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      ret_cnt;
  logic [CNT_W-1:0]     inf_q [NUM_CORES];
  logic [CNT_W-1:0]     inf_d [NUM_CORES];
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [NUM_CORES-1:0] vld_q, vld_d;
  logic [NUM_CORES-1:0] hs, elig;
  logic [1:0]           err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 kd_q, kd_d;
  logic                 found;
  int                   pick, hs_idx;
  logic [32:0]          bd_safe, nb_full;

  // 33-bit ceil-divide so num_threads near 2^32 cannot wrap
  assign bd_safe = {1'b0, (block_dim == '0) ? 32'd1 : block_dim};
  assign nb_full = ({1'b0, num_threads} + bd_safe - 33'd1) / bd_safe;
  assign hs      = vld_q & disp_ready;

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    next_d  = next_q;
    inf_d   = inf_q;
    rr_d    = rr_q;
    vld_d   = vld_q;
    id_d    = id_q;
    err_d   = err_q;
    ret_cnt = '0;
    elig    = '0;
    found   = 1'b0;
    pick    = 0;
    hs_idx  = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      elig[i] = inf_q[i] < CNT_W'(SLOTS_PER_CORE);
      if (hs[i]) begin
        hs_idx   = i;
        inf_d[i] = inf_q[i] + CNT_W'(1);
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (state_q != S_IDLE && core_done[i]) begin
        if (inf_q[i] != '0 || hs[i]) begin
          inf_d[i] = inf_d[i] - CNT_W'(1);
          ret_cnt  = ret_cnt + ID_W'(1);
        end else begin
          err_d[1] = 1'b1;
        end
      end
    end
    ret_d = ret_q + ret_cnt;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!found && elig[(int'(rr_q) + k) % NUM_CORES]) begin
        found = 1'b1;
        pick  = (int'(rr_q) + k) % NUM_CORES;
      end
    end
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (block_dim == '0) begin
            err_d[0] = 1'b1;
            state_d  = S_DONE;
          end else if (num_threads == '0) begin
            state_d = S_DONE;
          end else begin
            nb_d    = ID_W'(nb_full);
            next_d  = '0;
            ret_d   = '0;
            state_d = S_DISP;
          end
        end
      end
      S_DISP: begin
        if (hs != '0) begin
          vld_d  = '0;
          next_d = next_q + ID_W'(1);
          rr_d   = (hs_idx == NUM_CORES - 1) ? '0 : RR_W'(hs_idx + 1);
          if (next_d == nb_q)
            state_d = (ret_d == nb_q) ? S_DONE : S_DRAIN;
        end else if (vld_q == '0 && found) begin
          vld_d = NUM_CORES'(1) << pick;
          id_d  = next_q;
        end
      end
      S_DRAIN: begin
        if (ret_d == nb_q) state_d = S_DONE;
      end
      default: ;
    endcase
    busy_d = (state_d == S_DISP) || (state_d == S_DRAIN);
    kd_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      nb_q    <= '0;
      next_q  <= '0;
      ret_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      vld_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      kd_q    <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) inf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      next_q  <= next_d;
      ret_q   <= ret_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      kd_q    <= kd_d;
      for (int i = 0; i < NUM_CORES; i++) inf_q[i] <= inf_d[i];
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_inf
    assign core_inflight[g*CNT_W +: CNT_W] = inf_q[g];
  end

  assign busy          = busy_q;
  assign kernel_done   = kd_q;
  assign err           = err_q;
  assign disp_valid    = vld_q;
  assign disp_block_id = id_q;

`ifdef DISPATCH_STATS_EN
  logic [31:0] cyc_q, cyc_d, stall_q, stall_d;
  logic        stall_now, start_acc;

  always_comb begin
    cyc_d     = cyc_q;
    stall_d   = stall_q;
    start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
    stall_now = (state_q == S_DISP) &&
                ((vld_q == '0 && !found) || (vld_q != '0 && hs == '0));
    if (busy_q && cyc_q != '1) cyc_d = cyc_q + 32'd1;
    if (stall_now && stall_q != '1) stall_d = stall_q + 32'd1;
    if (start_acc) begin
      cyc_d   = '0;
      stall_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  assign stat_cycles = cyc_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: doc/block_dispatch_multislot.md
Name: block_dispatch_multislot

Overview:
Successor thread-block dispatcher. Hands block IDs to NUM_CORES compute units, each holding up to SLOTS_PER_CORE resident blocks. Uses a per-core valid/ready handshake and round-robin core selection. Sits between kernel-launch control and the compute-unit array, and signals kernel completion once every dispatched block has retired.

Parameters:
NUM_CORES, 4, number of compute units
SLOTS_PER_CORE, 2, max blocks resident per core (>=1)
ID_W, 32, block-ID width
CNT_W, $clog2(SLOTS_PER_CORE+1), per-core in-flight counter width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle kernel launch pulse; sampled only in IDLE or DONE
num_threads  in  32  threads in kernel; captured on accepted start
block_dim  in  32  threads per block; captured on accepted start
busy  out  1  high in DISPATCH or DRAIN
kernel_done  out  1  high in DONE; cleared by next accepted start
err  out  2  sticky; [0] block_dim==0 at start, [1] core_done with zero in-flight
disp_valid  out  NUM_CORES  one-hot offer of a block to core i
disp_ready  in  NUM_CORES  core i can accept a block this cycle
disp_block_id  out  ID_W  block ID on offer; shared bus
core_done  in  NUM_CORES  one-cycle pulse: core i retired one block
core_inflight  out  NUM_CORES*CNT_W  packed per-core resident count, core 0 in LSBs

Behaviour:
- Reset (rst low, async): state IDLE; busy=0, kernel_done=0, err=0, disp_valid=0, disp_block_id=0, all inflight=0, rr pointer=0, counters=0.
- num_blocks = ceil(num_threads/block_dim), computed in 33-bit arithmetic (no overflow at num_threads=2^32-1), registered on start. Upper bits beyond ID_W are truncated.
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE/DONE + start:
  - block_dim==0: set err[0], go to DONE.
  - num_threads==0: go to DONE next cycle; no dispatch.
  - otherwise: clear next_id, retired, kernel_done; go to DISPATCH.
- DISPATCH:
  - A core is eligible when inflight<SLOTS_PER_CORE.
  - With no offer pending, pick the first eligible core at or after rr, searching upward with wrap-around. Assert its disp_valid next cycle with disp_block_id=next_id.
  - Offer holds (valid and ID stable) until disp_ready on that core. Once made, an offer is never withdrawn or moved to another core.
  - On handshake: inflight[i]++, next_id++, rr=i+1 mod NUM_CORES.
  - A new offer may be issued in the cycle after a handshake, giving a sustained throughput of 1 block per 2 cycles. Registered outputs only.
  - When next_id==num_blocks after a handshake, go to DRAIN.
- DRAIN: no offers. When retired==num_blocks, go to DONE.
- Retire (any state except IDLE):
  - core_done[i] with inflight[i]>0: inflight[i]--, retired++.
  - core_done[i] with inflight[i]==0: set err[1]; counters unchanged.
  - Multiple cores may retire in the same cycle; retired adds the popcount.
- Handshake and core_done on the same core in the same cycle: inflight unchanged, next_id++, retired++.
- start while busy: ignored.
- kernel_done asserts in the cycle after the final retire; busy drops in the same cycle.
- Reset mid-kernel: all state discarded, outputs return to reset values immediately.

Optional Feature:
DISPATCH_STATS_EN
- Defined: adds outputs stat_cycles[31:0] and stat_stall[31:0], cleared on accepted start.
  - stat_cycles counts cycles with busy=1.
  - stat_stall counts DISPATCH cycles where blocks remain but no core is eligible, or an offer is pending without ready.
  - Both saturate at 2^32-1.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. num_threads=256, block_dim=64, NUM_CORES=4, SLOTS=2, all ready, done pulsed 5 cycles after each accept -> IDs 0..3 go to cores 0,1,2,3 in order; kernel_done after 4 retires; err=0.
2. num_threads=1000, block_dim=64 -> 16 blocks, IDs 0..15 each dispatched exactly once. With no core_done, all inflight=2 after 8 accepts and offers stop; a later core_done on core 2 causes the next offer to go to core 2.
3. disp_ready low on core 0 for 10 cycles -> disp_valid[0] and disp_block_id stay stable throughout; no other core receives that ID.
4. Same-cycle accept and core_done on core 1 at inflight=1 -> inflight[1] stays 1; retired and next_id both increment.
5. block_dim=0 -> err[0]=1, kernel_done=1, no disp_valid. num_threads=0 -> kernel_done=1 with no dispatch, err=0.
6. rst asserted low mid-DISPATCH with 3 blocks in flight -> outputs reset asynchronously. A new start with 128/64 then dispatches IDs 0,1 starting at core 0.
